// File: rtl/game_pkg.sv
// Shared game-flow types: sequencer states, game_active encodings and the
// default start-button geometry used by the sequencer and the class selector.
package game_pkg;

  typedef enum logic [2:0] {
    GS_MENU,
    GS_COUNTDOWN,
    GS_PLAYING,
    GS_END,
    GS_PAUSED
  } game_state_t;

  localparam logic [1:0] GAME_ACTIVE_MENU    = 2'd0;
  localparam logic [1:0] GAME_ACTIVE_PLAYING = 2'd1;
  localparam logic [1:0] GAME_ACTIVE_END     = 2'd2;
  localparam logic [1:0] GAME_ACTIVE_PAUSED  = 2'd3;

  localparam int START_BTN_X = 387;
  localparam int START_BTN_Y = 231;
  localparam int START_BTN_W = 250;
  localparam int START_BTN_H = 75;

  localparam int COUNTDOWN_FRAMES_DEF = 180;
  localparam int END_HOLD_FRAMES_DEF  = 120;

  // Inclusive-low, exclusive-high box test; one extra bit keeps x+w from wrapping.
  function automatic logic in_box(input logic [11:0] x, input logic [11:0] y,
                                  input int bx, input int by,
                                  input int bw, input int bh);
    logic [12:0] xe;
    logic [12:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    return (xe >= 13'(bx)) && (xe < 13'(bx + bw)) &&
           (ye >= 13'(by)) && (ye < 13'(by + bh));
  endfunction

endpackage

// File: rtl/game_flow_ctrl_edge_detect.sv
// Registered rising-edge detector: rise_o is high for one cycle, one cycle
// after sig_i goes from 0 to 1.
module game_flow_ctrl_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;
  logic rise_d;

  always_comb begin
    rise_d = sig_i & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: MENU -> COUNTDOWN -> PLAYING -> END -> MENU, with
// delays counted in vsync frames. Define GAME_FLOW_PAUSE_EN to add pause_btn/PAUSED.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int START_X          = START_BTN_X,
  parameter int START_Y          = START_BTN_Y,
  parameter int START_W          = START_BTN_W,
  parameter int START_H          = START_BTN_H,
  parameter int COUNTDOWN_FRAMES = COUNTDOWN_FRAMES_DEF,
  parameter int END_HOLD_FRAMES  = END_HOLD_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
`ifdef GAME_FLOW_PAUSE_EN
  input  logic        pause_btn,
`endif
  input  logic        vsync,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic        mouse_clicked,
  input  logic [1:0]  char_class,
  input  logic [3:0]  player_hp,
  input  logic [7:0]  boss_hp,
  output logic [1:0]  game_active,
  output logic        game_won,
  output logic [1:0]  countdown_sec,
  output logic        restart
);

  localparam int         SEC_FRAMES = COUNTDOWN_FRAMES / 3;
  localparam logic [7:0] CD_LAST    = 8'(COUNTDOWN_FRAMES - 1);
  localparam logic [7:0] END_HOLD   = 8'(END_HOLD_FRAMES);
  localparam logic [7:0] SEC2_AT    = 8'(SEC_FRAMES);
  localparam logic [7:0] SEC1_AT    = 8'(2 * SEC_FRAMES);

  generate
    if (COUNTDOWN_FRAMES < 3 || COUNTDOWN_FRAMES > 255 ||
        END_HOLD_FRAMES < 0 || END_HOLD_FRAMES > 255) begin : g_bad_frames
      $error("game_flow_ctrl: frame parameters must fit the 8-bit frame counter");
    end
  endgenerate

  logic click;
  logic tick;
  logic in_start;

  game_flow_ctrl_edge_detect u_click_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (mouse_clicked),
    .rise_o (click)
  );

  game_flow_ctrl_edge_detect u_tick_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (vsync),
    .rise_o (tick)
  );

`ifdef GAME_FLOW_PAUSE_EN
  logic pause;

  game_flow_ctrl_edge_detect u_pause_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (pause_btn),
    .rise_o (pause)
  );
`endif

  assign in_start = in_box(mouse_x, mouse_y, START_X, START_Y, START_W, START_H);

  // state_q is the observable FSM state for checkers and debug.
  game_state_t state_q;
  game_state_t state_d;
  logic [7:0]  frame_cnt_q;
  logic [7:0]  frame_cnt_d;
  logic        game_won_q;
  logic        game_won_d;
  logic        restart_q;
  logic        restart_d;
  logic [1:0]  game_active_q;
  logic [1:0]  game_active_d;
  logic [1:0]  countdown_sec_q;
  logic [1:0]  countdown_sec_d;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    game_won_d  = game_won_q;
    restart_d   = 1'b0;

    case (state_q)
      GS_MENU: begin
        if (click && in_start && (char_class != 2'd0)) begin
          state_d     = GS_COUNTDOWN;
          frame_cnt_d = 8'd0;
        end
      end
      GS_COUNTDOWN: begin
        if (tick) begin
          if (frame_cnt_q == CD_LAST) begin
            state_d = GS_PLAYING;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      GS_PLAYING: begin
        // A double knock-out is scored as a defeat.
        if (player_hp == 4'd0) begin
          state_d     = GS_END;
          game_won_d  = 1'b0;
          frame_cnt_d = 8'd0;
        end else if (boss_hp == 8'd0) begin
          state_d     = GS_END;
          game_won_d  = 1'b1;
          frame_cnt_d = 8'd0;
`ifdef GAME_FLOW_PAUSE_EN
        end else if (pause) begin
          state_d = GS_PAUSED;
`endif
        end
      end
      GS_END: begin
        if (tick && (frame_cnt_q < END_HOLD)) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (click && (frame_cnt_q == END_HOLD)) begin
          state_d     = GS_MENU;
          restart_d   = 1'b1;
          game_won_d  = 1'b0;
          frame_cnt_d = 8'd0;
        end
      end
      GS_PAUSED: begin
`ifdef GAME_FLOW_PAUSE_EN
        if (pause) begin
          state_d = GS_PLAYING;
        end
`else
        state_d = GS_MENU;
`endif
      end
      default: state_d = GS_MENU;
    endcase

    case (state_d)
      GS_PLAYING: game_active_d = GAME_ACTIVE_PLAYING;
      GS_END:     game_active_d = GAME_ACTIVE_END;
      GS_PAUSED:  game_active_d = GAME_ACTIVE_PAUSED;
      default:    game_active_d = GAME_ACTIVE_MENU;
    endcase

    countdown_sec_d = 2'd0;
    if (state_d == GS_COUNTDOWN) begin
      if (frame_cnt_d < SEC2_AT) begin
        countdown_sec_d = 2'd3;
      end else if (frame_cnt_d < SEC1_AT) begin
        countdown_sec_d = 2'd2;
      end else begin
        countdown_sec_d = 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= GS_MENU;
      frame_cnt_q     <= 8'd0;
      game_won_q      <= 1'b0;
      restart_q       <= 1'b0;
      game_active_q   <= GAME_ACTIVE_MENU;
      countdown_sec_q <= 2'd0;
    end else begin
      state_q         <= state_d;
      frame_cnt_q     <= frame_cnt_d;
      game_won_q      <= game_won_d;
      restart_q       <= restart_d;
      game_active_q   <= game_active_d;
      countdown_sec_q <= countdown_sec_d;
    end
  end

  assign game_active   = game_active_q;
  assign game_won      = game_won_q;
  assign countdown_sec = countdown_sec_q;
  assign restart       = restart_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: random click/vsync timing checked against a
// phase/frame-count model of the game flow. GAME_FLOW_PAUSE_EN adds the pause test.
`timescale 1ns/1ps
module tb_game_flow_ctrl;

  localparam int CD_FRAMES = 180;
  localparam int HOLD      = 120;
  localparam int BX = 387, BY = 231, BW = 250, BH = 75;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [11:0] mouse_x;
  logic [11:0] mouse_y;
  logic        mouse_clicked;
  logic [1:0]  char_class;
  logic [3:0]  player_hp;
  logic [7:0]  boss_hp;
  logic [1:0]  game_active;
  logic        game_won;
  logic [1:0]  countdown_sec;
  logic        restart;
`ifdef GAME_FLOW_PAUSE_EN
  logic        pause_btn;
`endif

  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .clk           (clk),
    .rst           (rst),
`ifdef GAME_FLOW_PAUSE_EN
    .pause_btn     (pause_btn),
`endif
    .vsync         (vsync),
    .mouse_x       (mouse_x),
    .mouse_y       (mouse_y),
    .mouse_clicked (mouse_clicked),
    .char_class    (char_class),
    .player_hp     (player_hp),
    .boss_hp       (boss_hp),
    .game_active   (game_active),
    .game_won      (game_won),
    .countdown_sec (countdown_sec),
    .restart       (restart)
  );

  int total = 0;
  int bad   = 0;

  // Model: phase 0 menu, 1 countdown, 2 playing, 3 end, 4 paused; m_frames = ticks seen in phase.
  int m_phase;
  int m_frames;
  bit m_won;
  bit m_restart;
  int restart_seen;

  function automatic logic [1:0] exp_active();
    case (m_phase)
      2:       return 2'd1;
      3:       return 2'd2;
      4:       return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_sec();
    return (m_phase == 1) ? 2'(3 - m_frames / (CD_FRAMES / 3)) : 2'd0;
  endfunction

  function automatic logic exp_won();
    return (m_phase == 3) ? m_won : 1'b0;
  endfunction

  function automatic logic obs_won();
    return (m_phase == 3) ? game_won : 1'b0;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_frames = 0; m_won = 0; m_restart = 0;
  endfunction

  function automatic void model_click(input int x, input int y);
    m_restart = 0;
    if (m_phase == 0 && x >= BX && x < BX + BW && y >= BY && y < BY + BH && char_class != 0) begin
      m_phase = 1; m_frames = 0;
    end else if (m_phase == 3 && m_frames >= HOLD) begin
      m_phase = 0; m_frames = 0; m_restart = 1;
    end
  endfunction

  function automatic void model_tick();
    if (m_phase == 1) begin
      m_frames++;
      if (m_frames == CD_FRAMES) m_phase = 2;
    end else if (m_phase == 3) begin
      if (m_frames < HOLD) m_frames++;
    end
  endfunction

  function automatic void model_hp();
    if (m_phase == 2) begin
      if (player_hp == 0) begin
        m_phase = 3; m_won = 0; m_frames = 0;
      end else if (boss_hp == 0) begin
        m_phase = 3; m_won = 1; m_frames = 0;
      end
    end
  endfunction

  // Press at (x,y) for 1..3 cycles, then let the registered edge settle; counts restart cycles seen.
  task automatic click_at(input int x, input int y);
    int hold;
    hold = $urandom_range(1, 3);
    mouse_x = 12'(x);
    mouse_y = 12'(y);
    mouse_clicked = 1'b1;
    restart_seen = 0;
    repeat (hold) begin @(negedge clk); restart_seen += int'(restart); end
    mouse_clicked = 1'b0;
    repeat (3) begin @(negedge clk); restart_seen += int'(restart); end
    model_click(x, y);
  endtask

  task automatic frame_tick();
    vsync = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    vsync = 1'b0;
    repeat ($urandom_range(2, 3)) @(negedge clk);
    model_tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    total++;
    if ({game_active, game_won, countdown_sec, restart} !== 6'd0) begin
      bad++;
      $display("FAIL reset_hold: active=%0d won=%0d sec=%0d restart=%0b, required all 0",
               game_active, game_won, countdown_sec, restart);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({game_active, game_won, countdown_sec, restart} !== 6'd0) begin
      bad++;
      $display("FAIL reset_release: active=%0d won=%0d sec=%0d restart=%0b, required all 0",
               game_active, game_won, countdown_sec, restart);
    end
  endtask

  task automatic test_class_gate();
    char_class = 2'd0;
    for (int i = 0; i < 3; i++) begin
      int x, y;
      x = (i == 0) ? 500 : int'($urandom_range(BX, BX + BW - 1));
      y = (i == 0) ? 260 : int'($urandom_range(BY, BY + BH - 1));
      click_at(x, y);
      total++;
      if (game_active !== exp_active() || countdown_sec !== exp_sec() || restart_seen != 0) begin
        bad++;
        $display("FAIL class_gate(%0d,%0d): active=%0d sec=%0d restarts=%0d, required %0d %0d 0",
                 x, y, game_active, countdown_sec, restart_seen, exp_active(), exp_sec());
      end
    end
  endtask

  task automatic test_hit_box();
    int xs[8];
    int ys[8];
    xs = '{386, 637, 500, 500, 386, 637, 0, 0};
    ys = '{260, 260, 230, 306, 230, 306, 0, 0};
    xs[6] = int'($urandom_range(0, BX - 1));        ys[6] = int'($urandom_range(0, 479));
    xs[7] = int'($urandom_range(BX + BW, 4095));    ys[7] = int'($urandom_range(BY, BY + BH - 1));
    char_class = 2'd1;
    for (int i = 0; i < 9; i++) begin
      int x, y;
      x = (i < 8) ? xs[i] : 500;
      y = (i < 8) ? ys[i] : 260;
      click_at(x, y);
      total++;
      if (game_active !== exp_active() || countdown_sec !== exp_sec()) begin
        bad++;
        $display("FAIL hit_box(%0d,%0d): active=%0d sec=%0d, required %0d %0d",
                 x, y, game_active, countdown_sec, exp_active(), exp_sec());
      end
    end
  endtask

  task automatic test_countdown();
    for (int t = 1; t <= CD_FRAMES; t++) begin
      frame_tick();
      if (t == 30) click_at(500, 260);
      total++;
      if (game_active !== exp_active() || countdown_sec !== exp_sec()) begin
        bad++;
        $display("FAIL countdown_tick%0d: active=%0d sec=%0d, required %0d %0d",
                 t, game_active, countdown_sec, exp_active(), exp_sec());
      end
    end
  endtask

  task automatic test_both_zero();
    repeat (4) begin
      player_hp = 4'($urandom_range(1, 15));
      boss_hp   = 8'($urandom_range(1, 255));
      frame_tick();
      total++;
      if (game_active !== exp_active()) begin
        bad++;
        $display("FAIL playing_hold: active=%0d, required %0d", game_active, exp_active());
      end
    end
    player_hp = 4'd0;
    boss_hp   = 8'd0;
    repeat (2) @(negedge clk);
    model_hp();
    total++;
    if (game_active !== exp_active() || obs_won() !== exp_won()) begin
      bad++;
      $display("FAIL both_zero: active=%0d won=%0b, required %0d %0b",
               game_active, game_won, exp_active(), exp_won());
    end
  endtask

  task automatic test_end_hold(input int extra);
    repeat (60) frame_tick();
    click_at(int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)));
    total++;
    if (game_active !== exp_active() || restart_seen != (m_restart ? 1 : 0)) begin
      bad++;
      $display("FAIL end_click60: active=%0d restarts=%0d, required %0d %0d",
               game_active, restart_seen, exp_active(), m_restart ? 1 : 0);
    end
    repeat (59) frame_tick();
    click_at(500, 260);
    total++;
    if (game_active !== exp_active() || obs_won() !== exp_won() || restart_seen != (m_restart ? 1 : 0)) begin
      bad++;
      $display("FAIL end_click119: active=%0d won=%0b restarts=%0d, required %0d %0b %0d",
               game_active, game_won, restart_seen, exp_active(), exp_won(), m_restart ? 1 : 0);
    end
    repeat (1 + extra) frame_tick();
    click_at(500, 260);
    total++;
    if (game_active !== exp_active() || restart_seen != (m_restart ? 1 : 0) || restart !== 1'b0) begin
      bad++;
      $display("FAIL end_click_hold: active=%0d restarts=%0d restart_now=%0b, required %0d %0d 0",
               game_active, restart_seen, restart, exp_active(), m_restart ? 1 : 0);
    end
    player_hp = 4'd5;
    boss_hp   = 8'd100;
  endtask

  task automatic test_boss_win();
    char_class = 2'd2;
    click_at(BX, BY);
    total++;
    if (game_active !== exp_active() || countdown_sec !== exp_sec()) begin
      bad++;
      $display("FAIL corner_click: active=%0d sec=%0d, required %0d %0d",
               game_active, countdown_sec, exp_active(), exp_sec());
    end
    repeat (CD_FRAMES) frame_tick();
    player_hp = 4'($urandom_range(1, 15));
    boss_hp   = 8'd0;
    repeat (2) @(negedge clk);
    model_hp();
    total++;
    if (game_active !== exp_active() || obs_won() !== exp_won()) begin
      bad++;
      $display("FAIL boss_win: active=%0d won=%0b, required %0d %0b",
               game_active, game_won, exp_active(), exp_won());
    end
    test_end_hold(int'($urandom_range(0, 8)));
  endtask

  task automatic test_reset_mid();
    char_class = 2'd1;
    click_at(BX + BW - 1, BY + BH - 1);
    repeat (90) frame_tick();
    total++;
    if (game_active !== exp_active() || countdown_sec !== exp_sec()) begin
      bad++;
      $display("FAIL tick90: active=%0d sec=%0d, required %0d %0d",
               game_active, countdown_sec, exp_active(), exp_sec());
    end
    mouse_x = 12'd100;
    mouse_y = 12'd100;
    mouse_clicked = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    total++;
    if ({game_active, game_won, countdown_sec, restart} !== 6'd0) begin
      bad++;
      $display("FAIL reset_mid: active=%0d won=%0d sec=%0d restart=%0b, required all 0",
               game_active, game_won, countdown_sec, restart);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mouse_x = 12'd500;
    mouse_y = 12'd260;
    repeat (6) @(negedge clk);
    total++;
    if (game_active !== exp_active() || countdown_sec !== exp_sec()) begin
      bad++;
      $display("FAIL held_click: active=%0d sec=%0d, required %0d %0d",
               game_active, countdown_sec, exp_active(), exp_sec());
    end
    mouse_clicked = 1'b0;
    @(negedge clk);
    click_at(500, 260);
    total++;
    if (game_active !== exp_active() || countdown_sec !== exp_sec()) begin
      bad++;
      $display("FAIL fresh_click: active=%0d sec=%0d, required %0d %0d",
               game_active, countdown_sec, exp_active(), exp_sec());
    end
  endtask

`ifdef GAME_FLOW_PAUSE_EN
  task automatic test_pause();
    repeat (CD_FRAMES) frame_tick();
    pause_btn = 1'b1;
    repeat (3) @(negedge clk);
    pause_btn = 1'b0;
    m_phase = 4;
    total++;
    if (game_active !== exp_active()) begin
      bad++;
      $display("FAIL pause_enter: active=%0d, required %0d", game_active, exp_active());
    end
    player_hp = 4'd0;
    repeat (3) frame_tick();
    total++;
    if (game_active !== exp_active()) begin
      bad++;
      $display("FAIL pause_hp0: active=%0d, required %0d", game_active, exp_active());
    end
    pause_btn = 1'b1;
    @(negedge clk);
    pause_btn = 1'b0;
    @(negedge clk);
    m_phase = 2;
    total++;
    if (game_active !== exp_active()) begin
      bad++;
      $display("FAIL pause_leave: active=%0d, required %0d", game_active, exp_active());
    end
    @(negedge clk);
    model_hp();
    total++;
    if (game_active !== exp_active() || obs_won() !== exp_won()) begin
      bad++;
      $display("FAIL pause_then_end: active=%0d won=%0b, required %0d %0b",
               game_active, game_won, exp_active(), exp_won());
    end
    player_hp = 4'd5;
  endtask
`endif

  initial begin
    rst = 1'b1;
    vsync = 1'b0;
    mouse_x = 12'd0;
    mouse_y = 12'd0;
    mouse_clicked = 1'b0;
    char_class = 2'd0;
    player_hp = 4'd5;
    boss_hp = 8'd100;
`ifdef GAME_FLOW_PAUSE_EN
    pause_btn = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    test_reset();
    test_class_gate();
    test_hit_box();
    test_countdown();
    test_both_zero();
    test_end_hold(int'($urandom_range(0, 8)));
    test_boss_win();
    test_reset_mid();
`ifdef GAME_FLOW_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
